// File: rtl/mem_bus_if.sv
// Data-bus request/acknowledge bundle between the MEM stage and memory.
// The master drives the registered request; the slave answers with ack and data.
interface mem_bus_if;
    logic        o_BusReq;
    logic        o_BusWe;
    logic [31:0] o_BusAddr;
    logic [31:0] o_BusWdata;
    logic [3:0]  o_BusBe;
    logic        i_BusAck;
    logic [31:0] i_BusRdata;

    modport master (
        output o_BusReq, o_BusWe, o_BusAddr, o_BusWdata, o_BusBe,
        input  i_BusAck, i_BusRdata
    );

    modport slave (
        input  o_BusReq, o_BusWe, o_BusAddr, o_BusWdata, o_BusBe,
        output i_BusAck, i_BusRdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: one req/ack bus transaction per memory instruction,
// pipeline stall while outstanding, aligned and extended load return.
module mem_access_stage #(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic        i_Clk,
    input  logic        Reset,
    input  logic        i_Valid,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic [1:0]  i_Size,
    input  logic        i_Unsigned,
    input  logic [31:0] i_ALUout,
    input  logic [31:0] i_WriteData,
    output logic [31:0] o_ReadData,
    output logic        o_Stall,
    output logic        o_AddrErr,
    output logic        o_BusErr,
    mem_bus_if.master   bus
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);
    localparam logic [TIMEOUT_W-1:0] CNT_ONE  = TIMEOUT_W'(1);

    state_t state, state_n;

    logic                 req_q, we_q, uns_q, berr_q;
    logic [31:0]          addr_q, wdata_q, rdata_q;
    logic [3:0]           be_q;
    logic [1:0]           size_q, lane_q;
    logic [TIMEOUT_W-1:0] cnt;

    logic [1:0]  lane;
    logic        is_byte, is_half, is_word;
    logic        aligned, mem_op, start, ack, tmo;
    logic [3:0]  be_n;
    logic [31:0] wdata_n, shifted, load_val;

    assign lane = i_ALUout[1:0];

    always_comb begin
        is_byte   = (i_Size == 2'b00);
        is_half   = (i_Size == 2'b01);
        is_word   = i_Size[1];
        aligned   = is_byte | (is_half & ~lane[0])
                  | (is_word & (lane == 2'b00));
        mem_op    = i_Valid & (i_MemRead | i_MemWrite);
        start     = ~Reset & mem_op & aligned & (state == S_IDLE);
        o_AddrErr = ~Reset & mem_op & ~aligned & (state == S_IDLE);
        o_Stall   = ~Reset & (start | (state == S_WAIT));
        ack       = (state == S_WAIT) & bus.i_BusAck;
        // Ack takes priority over an expiring counter
        tmo       = (state == S_WAIT) & ~bus.i_BusAck & (cnt == CNT_LAST);
    end

    always_comb begin
        be_n    = 4'b0001 << lane;
        wdata_n = {4{i_WriteData[7:0]}};
        unique case (1'b1)
            is_word: begin
                be_n    = 4'b1111;
                wdata_n = i_WriteData;
            end
            is_half: begin
                be_n    = 4'b0011 << lane;
                wdata_n = {2{i_WriteData[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted  = bus.i_BusRdata >> {lane_q, 3'b000};
        load_val = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
        unique case (1'b1)
            size_q[1]:
                load_val = bus.i_BusRdata;
            (size_q == 2'b01):
                load_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (start) state_n = S_WAIT;
            S_WAIT:  if (ack | tmo) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            berr_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= '0;
            size_q  <= '0;
            lane_q  <= '0;
            cnt     <= '0;
        end else begin
            state  <= state_n;
            berr_q <= tmo;
            if (start) begin
                req_q   <= 1'b1;
                we_q    <= i_MemWrite;
                addr_q  <= {i_ALUout[31:2], 2'b00};
                be_q    <= be_n;
                wdata_q <= wdata_n;
                size_q  <= i_Size;
                uns_q   <= i_Unsigned;
                lane_q  <= lane;
                cnt     <= '0;
            end
            if (state == S_WAIT) begin
                cnt <= cnt + CNT_ONE;
                if (ack | tmo) req_q <= 1'b0;
                if (ack & ~we_q) rdata_q <= load_val;
                if (tmo & ~we_q) rdata_q <= '0;
            end
        end
    end

    assign bus.o_BusReq   = req_q;
    assign bus.o_BusWe    = we_q;
    assign bus.o_BusAddr  = addr_q;
    assign bus.o_BusWdata = wdata_q;
    assign bus.o_BusBe    = be_q;
    assign o_ReadData     = rdata_q;
    assign o_BusErr       = berr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed loads/stores on two
// instances (default timeout and TIMEOUT=4), monitor-side checking.
module tb_mem_access_stage;

    typedef struct packed {
        logic        v;
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
    } cpu_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        logic [31:0] rd;
        logic        berr;
        int          stalls;
    } done_t;

    logic clk = 1'b0;
    logic rst;
    cpu_t cin_a, cin_b;
    logic [31:0] rd_a, rd_b, word_a, word_b;
    logic stall_a, stall_b, ae_a, ae_b, berr_a, berr_b;

    int vectors = 0;
    int miscompares = 0;
    int ae_pending = 0;
    int ack_at[2];
    int wcnt[2];
    int nstall[2];
    logic prev_req[2];
    req_t cur[2];
    req_t req_q[$];
    done_t done_q[$];

    mem_bus_if bus_a();
    mem_bus_if bus_b();

    always #5 clk = ~clk;

    mem_access_stage dut_a (
        .i_Clk(clk), .Reset(rst),
        .i_Valid(cin_a.v), .i_MemRead(cin_a.rd), .i_MemWrite(cin_a.wr),
        .i_Size(cin_a.sz), .i_Unsigned(cin_a.u),
        .i_ALUout(cin_a.a), .i_WriteData(cin_a.d),
        .o_ReadData(rd_a), .o_Stall(stall_a),
        .o_AddrErr(ae_a), .o_BusErr(berr_a), .bus(bus_a)
    );

    mem_access_stage #(.TIMEOUT(4), .TIMEOUT_W(8)) dut_b (
        .i_Clk(clk), .Reset(rst),
        .i_Valid(cin_b.v), .i_MemRead(cin_b.rd), .i_MemWrite(cin_b.wr),
        .i_Size(cin_b.sz), .i_Unsigned(cin_b.u),
        .i_ALUout(cin_b.a), .i_WriteData(cin_b.d),
        .o_ReadData(rd_b), .o_Stall(stall_b),
        .o_AddrErr(ae_b), .o_BusErr(berr_b), .bus(bus_b)
    );

    assign bus_a.i_BusRdata = word_a;
    assign bus_b.i_BusRdata = word_b;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name, input logic [127:0] act);
        vectors++;
        miscompares++;
        $display("FAIL %s: got %0h, nothing expected", name, act);
    endtask

    // Slave: ack on the ack_at-th WAIT cycle (0 = never)
    always @(posedge clk) begin
        #1;
        if (bus_a.o_BusReq) wcnt[0]++; else wcnt[0] = 0;
        if (bus_b.o_BusReq) wcnt[1]++; else wcnt[1] = 0;
        bus_a.i_BusAck = (ack_at[0] != 0) && (wcnt[0] == ack_at[0]);
        bus_b.i_BusAck = (ack_at[1] != 0) && (wcnt[1] == ack_at[1]);
    end

    task automatic mon(input int k, input logic r, req, stall, aerr, berr,
                       we, input logic [31:0] addr, wdata,
                       input logic [3:0] be, input logic [31:0] rdv);
        req_t  e;
        done_t d;
        if (r) begin
            prev_req[k] = 1'b0;
            nstall[k]   = 0;
        end else begin
            if (stall) nstall[k]++;
            if (req && !prev_req[k]) begin
                if (req_q.size() == 0) bad("unexpected_bus_req", addr);
                else begin
                    e = req_q.pop_front();
                    cur[k] = e;
                    chk("bus_we", we, e.we);
                    chk("bus_addr", addr, e.addr);
                    chk("bus_wdata", wdata, e.wdata);
                    chk("bus_be", be, e.be);
                end
            end else if (req) begin
                chk("bus_stable", {we, addr, wdata, be},
                    {cur[k].we, cur[k].addr, cur[k].wdata, cur[k].be});
            end
            if (!req && prev_req[k]) begin
                if (done_q.size() == 0) bad("unexpected_done", rdv);
                else begin
                    d = done_q.pop_front();
                    chk("read_data", rdv, d.rd);
                    chk("bus_err", berr, d.berr);
                    chk("stall_cycles", nstall[k], d.stalls);
                end
                nstall[k] = 0;
            end else if (berr) begin
                bad("stray_bus_err", berr);
            end
            if (aerr) begin
                if (ae_pending == 0) bad("unexpected_addr_err", aerr);
                else begin
                    ae_pending--;
                    chk("addr_err_stall", stall, 1'b0);
                end
            end
            prev_req[k] = req;
        end
    endtask

    always @(negedge clk) begin
        mon(0, rst, bus_a.o_BusReq, stall_a, ae_a, berr_a, bus_a.o_BusWe,
            bus_a.o_BusAddr, bus_a.o_BusWdata, bus_a.o_BusBe, rd_a);
        mon(1, rst, bus_b.o_BusReq, stall_b, ae_b, berr_b, bus_b.o_BusWe,
            bus_b.o_BusAddr, bus_b.o_BusWdata, bus_b.o_BusBe, rd_b);
    end

    task automatic expect_bus(input logic we, input logic [31:0] a, wd,
                              input logic [3:0] be, input logic [31:0] rdv,
                              input logic berr, input int st);
        req_q.push_back('{we, a, wd, be});
        done_q.push_back('{rdv, berr, st});
    endtask

    // Holds the instruction until the stage stops stalling, then retires it
    task automatic run(input int k, input logic rd, wr, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, d);
        cpu_t c;
        int   n;
        c = {1'b1, rd, wr, sz, u, a, d};
        if (k == 0) cin_a = c; else cin_b = c;
        n = 0;
        @(negedge clk);
        while (((k == 0) ? stall_a : stall_b) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if ((k == 0) ? stall_a : stall_b) bad("stall_timeout", n);
        @(posedge clk);
        #1;
        if (k == 0) cin_a = '0; else cin_b = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cin_a = '0;
        cin_b = '0;
        word_a = '0;
        word_b = '0;
        ack_at[0] = 0;
        ack_at[1] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_a", bus_a.o_BusReq, 1'b0);
        chk("rst_stall_a", stall_a, 1'b0);
        chk("rst_read_a", rd_a, 32'h0);
        chk("rst_addr_a", bus_a.o_BusAddr, 32'h0);
        chk("rst_req_b", bus_b.o_BusReq, 1'b0);
        chk("rst_bus_err_b", berr_b, 1'b0);
        @(posedge clk);
        #1;

        word_a = 32'h80FF_0000; ack_at[0] = 1;
        expect_bus(1'b0, 32'h1000, 32'h0, 4'b1000, 32'hFFFF_FF80, 1'b0, 2);
        run(0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h1003, 32'h0);

        word_a = 32'h8001_1234;
        expect_bus(1'b0, 32'h1000, 32'h0, 4'b1100, 32'h0000_8001, 1'b0, 2);
        run(0, 1'b1, 1'b0, 2'b01, 1'b1, 32'h1002, 32'h0);

        word_a = 32'h0000_F00D;
        expect_bus(1'b0, 32'h1000, 32'h0, 4'b0011, 32'hFFFF_F00D, 1'b0, 2);
        run(0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h1000, 32'h0);

        // Reset lands while the load is still waiting for ack
        ack_at[0] = 0;
        req_q.push_back('{1'b0, 32'h5000, 32'h0, 4'hF});
        cin_a = {1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h5000, 32'h0};
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        cin_a = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midwait_rst_req", bus_a.o_BusReq, 1'b0);
        chk("midwait_rst_stall", stall_a, 1'b0);
        chk("midwait_rst_read", rd_a, 32'h0);
        @(posedge clk);
        #1;

        word_a = 32'h0000_A500; ack_at[0] = 1;
        expect_bus(1'b0, 32'h2000, 32'h0, 4'b0010, 32'h0000_00A5, 1'b0, 2);
        run(0, 1'b1, 1'b0, 2'b00, 1'b1, 32'h2001, 32'h0);

        expect_bus(1'b1, 32'h2000, 32'hABCD_ABCD, 4'b1100, 32'h0000_00A5,
                   1'b0, 2);
        run(0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h2002, 32'h1234_ABCD);

        expect_bus(1'b1, 32'h1000, 32'h5A5A_5A5A, 4'b0010, 32'h0000_00A5,
                   1'b0, 2);
        run(0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h1001, 32'h1234_565A);

        run(0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h7000, 32'hFFFF_FFFF);
        chk("nonmem_read_kept", rd_a, 32'h0000_00A5);

        word_a = 32'hDEAD_BEEF; ack_at[0] = 5;
        expect_bus(1'b0, 32'h3000, 32'h1111_1111, 4'b1111, 32'hDEAD_BEEF,
                   1'b0, 6);
        run(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h3000, 32'h1111_1111);

        ae_pending++;
        run(0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h4001, 32'h0);
        ae_pending++;
        run(0, 1'b0, 1'b1, 2'b11, 1'b0, 32'h4002, 32'h0);
        chk("addr_err_seen", ae_pending, 0);
        chk("addr_err_read_kept", rd_a, 32'hDEAD_BEEF);

        word_b = 32'hBEEF_0000; ack_at[1] = 4;
        expect_bus(1'b0, 32'h6000, 32'h0, 4'b1100, 32'h0000_BEEF, 1'b0, 5);
        run(1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h6002, 32'h0);

        ack_at[1] = 0;
        expect_bus(1'b0, 32'h6000, 32'h0, 4'b1100, 32'h0, 1'b1, 5);
        run(1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h6002, 32'h0);

        repeat (2) @(posedge clk);
        chk("req_queue_drained", req_q.size(), 0);
        chk("done_queue_drained", done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
